// File: rtl/regfile_pkg.sv
// Shared constants and types for the 32x64 architectural register file.
package regfile_pkg;

    localparam int unsigned DATA_W   = 64;
    localparam int unsigned ADDR_W   = 5;
    localparam int unsigned ZERO_IDX = 31;
    localparam int unsigned NUM_REGS = 2 ** ADDR_W;

    typedef logic [ADDR_W-1:0] reg_idx_t;
    typedef logic [DATA_W-1:0] word_t;

    localparam reg_idx_t ZERO_REG = reg_idx_t'(ZERO_IDX);

endpackage

// File: rtl/decoder5to32.sv
// Write-port decoder: one-hot entry enable from write_reg, gated by reg_write.
module decoder5to32
    import regfile_pkg::*;
(
    input  logic [ADDR_W-1:0]   write_reg,
    input  logic                reg_write,
    output logic [NUM_REGS-1:0] en
);

    always_comb begin
        en = '0;
        // Logical AND keeps an X index from leaking into enables when reg_write=0.
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            en[i] = reg_write && (write_reg == reg_idx_t'(i));
        end
        en[ZERO_IDX] = 1'b0;
    end

endmodule

// File: rtl/reg64_en.sv
// 64-bit register with a per-bit write enable and asynchronous active-low clear.
module reg64_en
    import regfile_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] en,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    logic [DATA_W-1:0] q_q;
    logic [DATA_W-1:0] q_d;

    always_comb begin
        q_d = (en & d) | (~en & q_q);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/regfile32x64.sv
// 32x64 integer register file: two combinational read ports with write bypass,
// one synchronous write port, entry ZERO_IDX hard-wired to zero.
module regfile32x64
    import regfile_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] read_reg1,
    input  logic [ADDR_W-1:0] read_reg2,
    input  logic [ADDR_W-1:0] write_reg,
    input  logic [DATA_W-1:0] write_data,
    input  logic              reg_write,
    output logic [DATA_W-1:0] read_data1,
    output logic [DATA_W-1:0] read_data2
);

    logic [NUM_REGS-1:0]             wr_en;
    logic [NUM_REGS-1:0][DATA_W-1:0] entries;
    logic                            byp1;
    logic                            byp2;

    decoder5to32 u_dec (
        .write_reg (write_reg),
        .reg_write (reg_write),
        .en        (wr_en)
    );

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_entry
        if (g == ZERO_IDX) begin : g_zero
            logic unused_zero_en;
            assign unused_zero_en = wr_en[g];
            assign entries[g]     = '0;
        end else begin : g_reg
            reg64_en u_reg (
                .clk   (clk),
                .reset (reset),
                .en    ({DATA_W{wr_en[g]}}),
                .d     (write_data),
                .q     (entries[g])
            );
        end
    end

    // Forward writeback data to decode in the same cycle; never while in reset.
    always_comb begin
        byp1 = reset && reg_write && (write_reg == read_reg1) && (read_reg1 != ZERO_REG);
        byp2 = reset && reg_write && (write_reg == read_reg2) && (read_reg2 != ZERO_REG);
    end

    always_comb begin
        read_data1 = '0;
        if (reset && (read_reg1 != ZERO_REG)) begin
            read_data1 = byp1 ? write_data : entries[read_reg1];
        end
    end

    always_comb begin
        read_data2 = '0;
        if (reset && (read_reg2 != ZERO_REG)) begin
            read_data2 = byp2 ? write_data : entries[read_reg2];
        end
    end

endmodule

// File: tb/tb_regfile32x64.sv
// Directed bench for regfile32x64 with a reference model and expected-value queue.
module tb_regfile32x64;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  read_reg1;
    logic [4:0]  read_reg2;
    logic [4:0]  write_reg;
    logic [63:0] write_data;
    logic        reg_write;
    logic [63:0] read_data1;
    logic [63:0] read_data2;

    int total = 0;
    int bad   = 0;

    logic [63:0] model [32];
    logic [63:0] exp_q [$];
    string       tag_q [$];

    always #5 clk = ~clk;

    regfile32x64 dut (
        .clk        (clk),
        .reset      (reset),
        .read_reg1  (read_reg1),
        .read_reg2  (read_reg2),
        .write_reg  (write_reg),
        .write_data (write_data),
        .reg_write  (reg_write),
        .read_data1 (read_data1),
        .read_data2 (read_data2)
    );

    // Push expectations, let the read path settle, then pop and compare both ports.
    task automatic check(input string tag, input logic [4:0] r1, input logic [4:0] r2,
                         input logic [63:0] e1, input logic [63:0] e2);
        logic [63:0] e;
        string       t;
        read_reg1 = r1;
        read_reg2 = r2;
        exp_q.push_back(e1);
        exp_q.push_back(e2);
        tag_q.push_back(tag);
        #1;
        t = tag_q.pop_front();
        e = exp_q.pop_front();
        total++;
        assert (read_data1 === e) else begin
            bad++;
            $error("FAIL %s port1 r%0d: got %h expected %h", t, r1, read_data1, e);
        end
        e = exp_q.pop_front();
        total++;
        assert (read_data2 === e) else begin
            bad++;
            $error("FAIL %s port2 r%0d: got %h expected %h", t, r2, read_data2, e);
        end
    endtask

    task automatic do_write(input logic [4:0] idx, input logic [63:0] data);
        @(negedge clk);
        reg_write  = 1'b1;
        write_reg  = idx;
        write_data = data;
        @(posedge clk);
        #1;
        reg_write = 1'b0;
        if (idx != 5'd31) model[idx] = data;
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < 32; i++) begin
            check(tag, 5'(i), 5'(31 - i), model[i], model[31 - i]);
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) model[i] = '0;
        reset      = 1'b0;
        read_reg1  = '0;
        read_reg2  = '0;
        write_reg  = 5'd4;
        write_data = 64'hFF;
        reg_write  = 1'b1;

        // Reset held for two edges with a write pending: bypass suppressed, nothing stored.
        @(negedge clk);
        check("reset_bypass_off", 5'd4, 5'd4, 64'h0, 64'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reg_write = 1'b0;
        reset     = 1'b1;
        check_all("reset_zero");

        // Write then read.
        do_write(5'd5, 64'hDEAD_BEEF_0123_4567);
        check("write_read", 5'd5, 5'd6, 64'hDEAD_BEEF_0123_4567, 64'h0);

        // Zero register ignores writes and never bypasses.
        @(negedge clk);
        reg_write  = 1'b1;
        write_reg  = 5'd31;
        write_data = 64'hFFFF_FFFF_FFFF_FFFF;
        check("xzr_pre_edge", 5'd31, 5'd5, 64'h0, 64'hDEAD_BEEF_0123_4567);
        @(posedge clk);
        #1;
        reg_write = 1'b0;
        check("xzr_post_edge", 5'd31, 5'd31, 64'h0, 64'h0);
        check_all("xzr_others");

        // Bypass: without write enable the stored value is read.
        do_write(5'd7, 64'h11);
        @(negedge clk);
        write_reg  = 5'd7;
        write_data = 64'h22;
        reg_write  = 1'b0;
        check("no_bypass", 5'd7, 5'd7, 64'h11, 64'h11);
        reg_write = 1'b1;
        check("bypass_pre_edge", 5'd7, 5'd7, 64'h22, 64'h22);
        @(posedge clk);
        #1;
        reg_write = 1'b0;
        model[7]  = 64'h22;
        check("bypass_post_edge", 5'd7, 5'd7, 64'h22, 64'h22);
        check("bypass_one_port", 5'd7, 5'd5, 64'h22, 64'hDEAD_BEEF_0123_4567);

        // Enable gating over three edges.
        @(negedge clk);
        reg_write  = 1'b0;
        write_reg  = 5'd3;
        write_data = 64'hAAAA;
        repeat (3) @(posedge clk);
        #1;
        check("enable_gating", 5'd3, 5'd3, 64'h0, 64'h0);

        // Unknown write index with write disabled must not disturb storage.
        @(negedge clk);
        write_reg  = 5'bx;
        write_data = 64'hBAD0_BAD0_BAD0_BAD0;
        repeat (2) @(posedge clk);
        #1;
        write_reg = 5'd0;
        check_all("x_index_idle");

        // Async reset mid-cycle clears immediately; a write during reset is lost.
        do_write(5'd10, 64'h5555);
        check("x10_stored", 5'd10, 5'd10, 64'h5555, 64'h5555);
        @(posedge clk);
        #3;
        reset = 1'b0;
        for (int i = 0; i < 32; i++) model[i] = '0;
        check("async_clear", 5'd10, 5'd5, 64'h0, 64'h0);
        @(negedge clk);
        reg_write  = 1'b1;
        write_reg  = 5'd10;
        write_data = 64'h77;
        check("write_in_reset", 5'd10, 5'd10, 64'h0, 64'h0);
        @(posedge clk);
        @(negedge clk);
        reg_write = 1'b0;
        reset     = 1'b1;
        check("after_reset_x10", 5'd10, 5'd7, 64'h0, 64'h0);
        check_all("after_reset_all");

        // Normal operation resumes after reset.
        do_write(5'd0, 64'h0123_4567_89AB_CDEF);
        check("post_reset_write", 5'd0, 5'd10, 64'h0123_4567_89AB_CDEF, 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile32x64.md
Name: regfile32x64

Overview:
- Architectural integer register file for the 64-bit datapath: 32 entries × 64 bits, two combinational read ports, one synchronous write port.
- Sits directly downstream of the per-bit enabled 64-bit register and is built from those registers. A write decoder drives each register's enable.
- Read ports feed the ALU/operand stage. The write port is driven by writeback.
- Entry 31 is the zero register (XZR): it always reads 0 and ignores writes.

Parameters:
- DATA_W, 64, data width of each entry and of all data ports.
- ADDR_W, 5, register index width; number of entries = 2**ADDR_W.
- ZERO_IDX, 31, index hard-wired to read zero and discard writes.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- read_reg1  input  ADDR_W  index for read port 1.
- read_reg2  input  ADDR_W  index for read port 2.
- write_reg  input  ADDR_W  index for the write port.
- write_data  input  DATA_W  data to write.
- reg_write  input  1  write enable.
- read_data1  output  DATA_W  contents of read_reg1 (bypassed, see Behaviour).
- read_data2  output  DATA_W  contents of read_reg2 (bypassed, see Behaviour).

Behaviour:
- Reset:
  - reset=0 clears all 32 entries to 0 immediately, with no clock edge needed.
  - While reset=0, read_data1 and read_data2 are 0 and bypass is suppressed.
  - Deasserting reset mid-cycle takes effect at the next rising edge; no partial write.
- Write:
  - At a rising clk edge with reset=1, reg_write=1 and write_reg!=ZERO_IDX, entry[write_reg] <= write_data.
  - All other entries hold; each entry's enable is asserted only by the decoder.
  - reg_write=0 or write_reg==ZERO_IDX leaves every entry unchanged.
  - Write latency: 1 edge, new value visible in storage after the edge.
- Read:
  - Combinational, zero latency. read_dataN = entry[read_regN].
  - read_regN==ZERO_IDX returns 0 regardless of bypass or stored state.
- Write-read bypass (same-cycle forwarding for the writeback→decode hazard):
  - If reg_write=1, write_reg==read_regN and read_regN!=ZERO_IDX, then read_dataN = write_data in the same cycle, before the edge.
  - Both ports bypass independently. read_reg1==read_reg2==write_reg gives both ports write_data.
- Simultaneous events:
  - A reset assertion coincident with a write edge: reset wins, entry stays 0.
  - X/Z on an unused index when reg_write=0 must not corrupt any entry.
- No storage for entry 31. The implementation synthesises the zero constant; no flop is required.
- No state machine. All sequential state is the 31×64 enabled flops; enables = decoder(write_reg) & reg_write.

Decomposition:
- Shared package regfile_pkg: DATA_W, ADDR_W, ZERO_IDX constants, NUM_REGS = 2**ADDR_W, and the typedefs reg_idx_t (logic [ADDR_W-1:0]) and word_t (logic [DATA_W-1:0]).
- Storage uses the existing 64-bit enabled register, one instance per entry in a generate loop.
- One natural new sub-module: decoder5to32.
  - One-hot write enable from write_reg gated by reg_write.
  - Bit ZERO_IDX is forced 0.
- Read muxing (32:1 per port) and bypass stay in the top.

Test Plan:
- Reset and zero: reset=0 for 2 cycles, then reset=1 → every read_reg1/read_reg2 in 0..31 returns 0x0.
- Write then read:
  - Write X5=64'hDEAD_BEEF_0123_4567 with reg_write=1 for one edge, then reg_write=0.
  - read_reg1=5 → 64'hDEAD_BEEF_0123_4567; read_reg2=6 → 0.
- XZR:
  - Write X31=64'hFFFF_FFFF_FFFF_FFFF.
  - read_reg1=31 → 0, both during the write cycle (no bypass) and after it.
  - All other entries unchanged.
- Bypass:
  - X7 holds 64'h11. Drive reg_write=1, write_reg=7, write_data=64'h22, read_reg1=read_reg2=7 before the edge.
  - Both reads → 64'h22 pre-edge and still 64'h22 post-edge. With reg_write=0 pre-edge instead, reads → 64'h11.
- Enable gating: reg_write=0, write_reg=3, write_data=64'hAAAA over 3 edges → X3 stays at its prior value (0 after reset).
- Async reset mid-operation:
  - X10=64'h5555 stored. Pull reset=0 at mid-cycle with no clock edge → read_reg1=10 → 0 immediately.
  - Keep reset=0 through a write edge to X10=64'h77 → X10 stays 0 after reset=1.
